renkon_accum: RTL

//  Per-pixel multiply-accumulate back end of the renkon conv pipeline.

---
 rtl/renkon_accum_pkg.sv | 27 ++
 rtl/renkon_sat.sv | 55 +++++
 rtl/renkon_accum.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/renkon_accum_pkg.sv
// renkon_accum_pkg
//   Shared defaults and types for the renkon accumulate back end.
//   - Default word, fraction, accumulator and counter widths.
//   - FSM state encoding (2 bits): S_IDLE, S_ACC, S_DONE.
//   - sadd_ovf(): signed-overflow detection for a two's-complement add,
//     computed from the operand and result sign bits.
package renkon_accum_pkg;

  localparam int RENKON_DWIDTH = 16;
  localparam int RENKON_FBITS  = 8;
  localparam int RENKON_AWIDTH = 2 * RENKON_DWIDTH + 8;
  localparam int RENKON_CWIDTH = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Adding two operands that share a sign, and getting a result of the
  // other sign, is a signed overflow.
  function automatic logic sadd_ovf(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/renkon_sat.sv
// renkon_sat
//   Combinational rescale and saturate: converts an AWIDTH accumulator with
//   2*FBITS fraction bits to a DWIDTH signed word with FBITS fraction bits.
//   Optional macro RENKON_ACCUM_ROUND_EN: when defined, the value is rounded
//   half up before the shift; when undefined it is truncated toward -inf.
// Ports
//   i_acc    in   AWIDTH  signed accumulator value
//   o_pixel  out  DWIDTH  rescaled, clipped result
//   o_sat    out  1       1 when o_pixel was clipped
module renkon_sat #(
  parameter int DWIDTH = 16,
  parameter int FBITS  = 8,
  parameter int AWIDTH = 2 * DWIDTH + 8
) (
  input  logic [AWIDTH-1:0] i_acc,
  output logic [DWIDTH-1:0] o_pixel,
  output logic              o_sat
);

  // Clip limits, built at AWIDTH+1 bits so they compare directly with w_s.
  localparam logic signed [AWIDTH:0] MAXV =
    $signed({{(AWIDTH-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}});
  localparam logic signed [AWIDTH:0] MINV =
    $signed({{(AWIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}});

  logic signed [AWIDTH:0] w_ext;
  logic signed [AWIDTH:0] w_s;
  logic                   w_hi;
  logic                   w_lo;

  // One extra bit of headroom so the rounding add can never wrap.
`ifdef RENKON_ACCUM_ROUND_EN
  assign w_ext = $signed({i_acc[AWIDTH-1], i_acc})
               + $signed((AWIDTH+1)'(1) << (FBITS - 1));
`else
  assign w_ext = $signed({i_acc[AWIDTH-1], i_acc});
`endif

  assign w_s  = w_ext >>> FBITS;
  assign w_hi = (w_s > MAXV);
  assign w_lo = (w_s < MINV);

  always_comb begin
    o_pixel = w_s[DWIDTH-1:0];
    o_sat   = 1'b0;
    if (w_hi) begin
      o_pixel = MAXV[DWIDTH-1:0];
      o_sat   = 1'b1;
    end else if (w_lo) begin
      o_pixel = MINV[DWIDTH-1:0];
      o_sat   = 1'b1;
    end
  end

endmodule

// File: rtl/renkon_accum.sv
// renkon_accum
//   Per-pixel multiply-accumulate back end of the renkon conv pipeline.
//   Sums signed product terms; on the term tagged in_last, the sum is
//   rescaled/saturated (renkon_sat) and presented on pixel_out with a
//   one-cycle out_valid pulse. A new pixel may start in the S_DONE cycle,
//   so 1-term pixels can stream every cycle.
//   Optional macro RENKON_ACCUM_ROUND_EN (handled inside renkon_sat):
//   round half up before the shift instead of truncating.
// Handshake: no backpressure. A term is consumed on every rising edge where
//   in_valid=1 (in_last is only meaningful with in_valid). out_valid is a
//   single-cycle pulse; pixel_out/term_cnt/sat_flag hold until the next one.
// Ports
//   clk        in   1         clock, rising edge
//   xrst       in   1         asynchronous reset, active high
//   acc_clr    in   1         synchronous abort of the pixel in flight
//   in_valid   in   1         prod_in/in_last valid
//   in_last    in   1         final term of current pixel
//   prod_in    in   2*DWIDTH  signed product term
//   out_valid  out  1         result pulse
//   pixel_out  out  DWIDTH    signed result
//   term_cnt   out  CWIDTH    terms summed into pixel_out
//   sat_flag   out  1         pixel_out was clipped
//   acc_ovf    out  1         sticky accumulator/counter overflow
// The FSM state is held in r_state (state_e) for checkers to bind to.
module renkon_accum
  import renkon_accum_pkg::*;
#(
  parameter int DWIDTH = RENKON_DWIDTH,
  parameter int FBITS  = RENKON_FBITS,
  parameter int AWIDTH = RENKON_AWIDTH,
  parameter int CWIDTH = RENKON_CWIDTH
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                acc_clr,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [2*DWIDTH-1:0] prod_in,
  output logic                out_valid,
  output logic [DWIDTH-1:0]   pixel_out,
  output logic [CWIDTH-1:0]   term_cnt,
  output logic                sat_flag,
  output logic                acc_ovf
);

  state_e              r_state;
  logic [AWIDTH-1:0]   r_acc;
  logic [CWIDTH-1:0]   r_cnt;
  logic                r_out_valid;
  logic [DWIDTH-1:0]   r_pixel;
  logic [CWIDTH-1:0]   r_term_cnt;
  logic                r_sat;
  logic                r_acc_ovf;

  logic [AWIDTH-1:0]   w_prod_ext;
  logic [AWIDTH-1:0]   w_sum;
  logic                w_add_ovf;
  logic                w_cnt_max;
  logic [DWIDTH-1:0]   w_pixel;
  logic                w_sat;
  state_e              w_next_on_term;

  assign w_prod_ext = {{(AWIDTH-2*DWIDTH){prod_in[2*DWIDTH-1]}}, prod_in};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = sadd_ovf(r_acc[AWIDTH-1], w_prod_ext[AWIDTH-1],
                               w_sum[AWIDTH-1]);
  assign w_cnt_max  = &r_cnt;
  assign w_next_on_term = in_last ? S_DONE : S_ACC;

  renkon_sat #(
    .DWIDTH (DWIDTH),
    .FBITS  (FBITS),
    .AWIDTH (AWIDTH)
  ) u_sat (
    .i_acc   (r_acc),
    .o_pixel (w_pixel),
    .o_sat   (w_sat)
  );

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_pixel     <= '0;
      r_term_cnt  <= '0;
      r_sat       <= 1'b0;
      r_acc_ovf   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (acc_clr) begin
        // Abort wins over everything, including a pending S_DONE result
        // and a term offered in the same cycle.
        r_state <= S_IDLE;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              r_acc   <= w_prod_ext;
              r_cnt   <= CWIDTH'(1);
              r_state <= w_next_on_term;
            end
          end
          S_ACC: begin
            if (in_valid) begin
              r_acc <= w_sum;
              // Counter sticks at all-ones and flags the overflow.
              if (w_cnt_max) r_acc_ovf <= 1'b1;
              else           r_cnt     <= r_cnt + CWIDTH'(1);
              if (w_add_ovf) r_acc_ovf <= 1'b1;
              r_state <= w_next_on_term;
            end
          end
          S_DONE: begin
            r_pixel     <= w_pixel;
            r_sat       <= w_sat;
            r_term_cnt  <= r_cnt;
            r_out_valid <= 1'b1;
            // A term arriving now opens the next pixel without a bubble.
            if (in_valid) begin
              r_acc   <= w_prod_ext;
              r_cnt   <= CWIDTH'(1);
              r_state <= w_next_on_term;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign pixel_out = r_pixel;
  assign term_cnt  = r_term_cnt;
  assign sat_flag  = r_sat;
  assign acc_ovf   = r_acc_ovf;

endmodule
